// File: rtl/game_pkg.sv
// Shared types and constants for the obstacle datapath of the flappy-bird game.
// Latency: n/a (package only). Backpressure: n/a.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [1:0] LVL_EASY = 2'd0;
    localparam logic [1:0] LVL_MED  = 2'd1;
    localparam logic [1:0] LVL_HARD = 2'd2;

    localparam logic [7:0] GAP_EASY = 8'd210;
    localparam logic [7:0] GAP_MED  = 8'd150;
    localparam logic [7:0] GAP_HARD = 8'd130;
    localparam logic [7:0] OSC_LO   = 8'd130;
    localparam logic [7:0] OSC_HI   = 8'd160;

    localparam logic [9:0] SPAWN_COL = 10'd610;
    localparam logic [9:0] MIN_COL   = 10'd25;
    localparam logic [9:0] STEP      = 10'd2;

    localparam logic [7:0] INIT_CNT = 8'd140;
    localparam logic [7:0] PERIOD   = 8'd120;
    localparam logic [7:0] SPAWN_AT = 8'd119;

    typedef struct packed {
        logic [8:0] row;
        logic [9:0] col;
    } slot_t;

    function automatic logic [7:0] gap_for_level(input logic [1:0] lvl);
        case (lvl)
            LVL_MED:  return GAP_MED;
            LVL_HARD: return GAP_HARD;
            default:  return GAP_EASY;
        endcase
    endfunction

    // Snapping below MIN_COL keeps the unsigned subtraction from wrapping.
    function automatic logic [9:0] next_col(input logic [9:0] col);
        return (col >= MIN_COL) ? (col - STEP) : 10'd0;
    endfunction

endpackage

// File: rtl/obstacle_scheduler_if.sv
// Control inputs and obstacle outputs of the scheduler, bundled for the game top.
// Latency: n/a (wiring only). Backpressure: none, outputs are plain registers.
interface obstacle_scheduler_if;
    logic       tick;
    logic       start;
    logic       run;
    logic       clear;
    logic [1:0] level;
    logic [8:0] rand_row;
    logic [8:0] obs_row0;
    logic [8:0] obs_row1;
    logic [8:0] obs_row2;
    logic [9:0] obs_col0;
    logic [9:0] obs_col1;
    logic [9:0] obs_col2;
    logic [7:0] gap_height;
    logic       spawn;
    logic       active;

    modport master (
        output tick, start, run, clear, level, rand_row,
        input  obs_row0, obs_row1, obs_row2, obs_col0, obs_col1, obs_col2,
        input  gap_height, spawn, active
    );

    modport slave (
        input  tick, start, run, clear, level, rand_row,
        output obs_row0, obs_row1, obs_row2, obs_col0, obs_col1, obs_col2,
        output gap_height, spawn, active
    );
endinterface

// File: rtl/gap_oscillator.sv
// Holds the gap height and sweeps it between OSC_LO and OSC_HI when enabled.
// Latency: 1 cycle from load/step to gap_height. Backpressure: none.
module gap_oscillator
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       en,
    input  logic       step,
    output logic [7:0] gap_height
);
    logic dir;

    // Out-of-band values bounce back by 2 so the sweep turns around in one step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_height <= 8'd0;
            dir        <= 1'b1;
        end else if (load) begin
            gap_height <= load_val;
            dir        <= 1'b1;
        end else if (en && step) begin
            if (gap_height > OSC_HI) begin
                dir        <= 1'b0;
                gap_height <= gap_height - 8'd2;
            end else if (gap_height < OSC_LO) begin
                dir        <= 1'b1;
                gap_height <= gap_height + 8'd2;
            end else begin
                gap_height <= dir ? (gap_height + 8'd1) : (gap_height - 8'd1);
            end
        end
    end
endmodule

// File: rtl/obstacle_scheduler.sv
// Spawns, shifts and moves the three obstacle slots on frame ticks; drives gap height.
// Latency: 1 cycle from tick to registered outputs. Backpressure: run=0 freezes (HOLD).
module obstacle_scheduler
    import game_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    obstacle_scheduler_if.slave  bus
);
    state_t        state_q, state_d;
    slot_t [2:0]   slot_q;
    logic  [7:0]   cnt_q;
    logic          osc_en_q;
    logic          spawn_q;
    logic  [7:0]   gap_height;

    logic do_clear, do_load, do_spawn, do_reload, do_move;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        do_clear  = 1'b0;
        do_load   = 1'b0;
        do_spawn  = 1'b0;
        do_reload = 1'b0;
        do_move   = 1'b0;
        if (bus.clear) begin
            state_d  = ST_IDLE;
            do_clear = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.start) state_d = ST_LOAD;
                ST_LOAD: begin
                    do_load = 1'b1;
                    state_d = bus.start ? ST_LOAD : ST_RUN;
                end
                ST_RUN: begin
                    if (bus.start)      state_d = ST_LOAD;
                    else if (!bus.run)  state_d = ST_HOLD;
                    else if (bus.tick) begin
                        if (cnt_q == SPAWN_AT)   do_spawn  = 1'b1;
                        else if (cnt_q == 8'd0)  do_reload = 1'b1;
                        else                     do_move   = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.start)    state_d = ST_LOAD;
                    else if (bus.run) state_d = ST_RUN;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q   <= '0;
            cnt_q    <= 8'd0;
            osc_en_q <= 1'b0;
            spawn_q  <= 1'b0;
        end else begin
            spawn_q <= do_spawn;
            if (do_clear || do_load) slot_q <= '0;
            if (do_load) begin
                cnt_q    <= INIT_CNT;
                osc_en_q <= (bus.level == LVL_HARD);
            end
            if (do_spawn) begin
                slot_q <= {slot_q[1], slot_q[0], slot_t'{row: bus.rand_row, col: SPAWN_COL}};
                cnt_q  <= cnt_q - 8'd1;
            end
            if (do_reload) cnt_q <= PERIOD;
            if (do_move) begin
                cnt_q <= cnt_q - 8'd1;
                for (int i = 0; i < 3; i++) slot_q[i].col <= next_col(slot_q[i].col);
            end
        end
    end

    gap_oscillator u_gap (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (do_load),
        .load_val   (gap_for_level(bus.level)),
        .en         (osc_en_q),
        .step       (do_move),
        .gap_height (gap_height)
    );

    assign bus.obs_row0   = slot_q[0].row;
    assign bus.obs_row1   = slot_q[1].row;
    assign bus.obs_row2   = slot_q[2].row;
    assign bus.obs_col0   = slot_q[0].col;
    assign bus.obs_col1   = slot_q[1].col;
    assign bus.obs_col2   = slot_q[2].col;
    assign bus.gap_height = gap_height;
    assign bus.spawn      = spawn_q;
    assign bus.active     = (state_q == ST_RUN) || (state_q == ST_HOLD);
endmodule

// File: tb/tb_obstacle_scheduler.sv
// Scoreboarded bench for obstacle_scheduler: tick-index reference model plus directed checks.
module tb_obstacle_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    obstacle_scheduler_if bus ();

    obstacle_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef logic [66:0] snap_t;
    snap_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int tick_no = 0;

    // Reference model: mode 0 idle, 1 load, 2 run, 3 hold; m_n counts active ticks since load.
    int m_mode, m_n, m_gap, m_dir;
    int m_row[3];
    int m_col[3];
    bit m_osc, m_spawn;

    function automatic snap_t model_snap();
        bit act;
        act = (m_mode == 2) || (m_mode == 3);
        return {9'(m_row[0]), 9'(m_row[1]), 9'(m_row[2]),
                10'(m_col[0]), 10'(m_col[1]), 10'(m_col[2]),
                8'(m_gap), m_spawn, act};
    endfunction

    function automatic snap_t dut_snap();
        return {bus.obs_row0, bus.obs_row1, bus.obs_row2,
                bus.obs_col0, bus.obs_col1, bus.obs_col2,
                bus.gap_height, bus.spawn, bus.active};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_n = 0; m_gap = 0; m_dir = 1; m_osc = 0; m_spawn = 0;
        for (int i = 0; i < 3; i++) begin m_row[i] = 0; m_col[i] = 0; end
    endtask

    task automatic model_step(input bit t, input bit r, input bit s, input bit c,
                              input int lvl, input int row);
        int k;
        m_spawn = 0;
        if (c) begin
            m_mode = 0;
            for (int i = 0; i < 3; i++) begin m_row[i] = 0; m_col[i] = 0; end
        end else if (m_mode == 1) begin
            for (int i = 0; i < 3; i++) begin m_row[i] = 0; m_col[i] = 0; end
            m_n   = 0;
            m_gap = (lvl == 1) ? 150 : (lvl == 2) ? 130 : 210;
            m_dir = 1;
            m_osc = (lvl == 2);
            m_mode = s ? 1 : 2;
        end else if (s) begin
            m_mode = 1;
        end else if (m_mode == 2) begin
            if (!r) m_mode = 3;
            else if (t) begin
                m_n++;
                k = m_n - 22;
                if (k >= 0 && (k % 121) == 0) begin
                    m_row[2] = m_row[1]; m_col[2] = m_col[1];
                    m_row[1] = m_row[0]; m_col[1] = m_col[0];
                    m_row[0] = row;      m_col[0] = 610;
                    m_spawn = 1;
                end else if (!(k >= 0 && (k % 121) == 119)) begin
                    for (int i = 0; i < 3; i++) m_col[i] = (m_col[i] < 25) ? 0 : m_col[i] - 2;
                    if (m_osc) begin
                        if (m_gap > 160)      begin m_dir = 0; m_gap -= 2; end
                        else if (m_gap < 130) begin m_dir = 1; m_gap += 2; end
                        else m_gap += m_dir ? 1 : -1;
                    end
                end
            end
        end else if (m_mode == 3 && r) begin
            m_mode = 2;
        end
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs at negedge, record the model's post-edge expectation.
    task automatic cyc(input bit t, input bit r, input bit s, input bit c);
        @(negedge clk);
        bus.tick = t; bus.run = r; bus.start = s; bus.clear = c;
        bus.rand_row = 9'($urandom_range(0, 479));
        if (rst_n) model_step(t, r, s, c, int'(bus.level), int'(bus.rand_row));
        else       model_reset();
        exp_q.push_back(model_snap());
        @(posedge clk);
        #2;
    endtask

    task automatic do_tick();
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        tick_no++;
    endtask

    task automatic start_level(input logic [1:0] lvl);
        bus.level = lvl;
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        tick_no = 0;
    endtask

    initial begin : monitor
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (dut_snap() !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t: got %h, expected %h", $time, dut_snap(), e);
                end
            end
        end
    end

    initial begin : stimulus
        int first_sp, second_sp, found, gmin, gmax, range_bad;
        snap_t hold_ref;
        bus.tick = 0; bus.run = 0; bus.start = 0; bus.clear = 0;
        bus.level = 0; bus.rand_row = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check("reset_outputs", longint'(dut_snap()), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Easy level: spawn timing and spacing.
        start_level(2'd0);
        check("load_active", bus.active, 1);
        check("load_gap", bus.gap_height, 210);
        first_sp = 0; second_sp = 0;
        for (int k = 1; k <= 150; k++) begin
            do_tick();
            if (bus.spawn) begin
                if (first_sp == 0) first_sp = tick_no;
                else if (second_sp == 0) second_sp = tick_no;
            end
            if (tick_no == 143) begin
                check("second_spawn_col1", bus.obs_col1, 372);
                check("second_spawn_col0", bus.obs_col0, 610);
                check("easy_gap_const", bus.gap_height, 210);
            end
        end
        check("first_spawn_tick", first_sp, 22);
        check("second_spawn_tick", second_sp, 143);

        // Pause: 50 ticks with run low change nothing.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        hold_ref = model_snap();
        repeat (50) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("hold_frozen", longint'(dut_snap()), longint'(hold_ref));
        check("hold_active", bus.active, 1);
        found = 0;
        for (int k = 0; k < 130 && found == 0; k++) begin
            do_tick();
            if (bus.spawn) found = tick_no;
        end
        check("resume_spawn_tick", found, 264);

        // Oldest obstacle walks down to the snap boundary.
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            do_tick();
            if (bus.obs_col2 == 10'd26) found = tick_no;
        end
        check("col26_tick", found, 318);
        do_tick();
        check("col_24", bus.obs_col2, 24);
        do_tick();
        check("col_snap0", bus.obs_col2, 0);
        do_tick();
        check("col_stays0", bus.obs_col2, 0);

        // clear beats start.
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        check("clr_active", bus.active, 0);
        check("clr_slots", {bus.obs_col0, bus.obs_col1, bus.obs_col2, bus.obs_row0}, 0);
        check("clr_spawn", bus.spawn, 0);
        check("clr_gap_kept", bus.gap_height, 210);
        repeat (4) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("idle_stays", bus.active, 0);

        // Hard level oscillation.
        start_level(2'd2);
        gmin = 255; gmax = 0; range_bad = 0;
        for (int k = 1; k <= 205; k++) begin
            do_tick();
            if (bus.gap_height < gmin) gmin = bus.gap_height;
            if (bus.gap_height > gmax) gmax = bus.gap_height;
            if (bus.gap_height < 128 || bus.gap_height > 162) range_bad++;
            if (tick_no == 32) check("osc_peak", bus.gap_height, 161);
            if (tick_no == 33) check("osc_turn_down", bus.gap_height, 159);
            if (tick_no == 63) check("osc_trough", bus.gap_height, 129);
            if (tick_no == 64) check("osc_turn_up", bus.gap_height, 131);
        end
        check("osc_range", range_bad, 0);
        check("osc_max", gmax, 161);
        check("osc_min", gmin, 129);

        // Asynchronous reset with a tick pending.
        @(negedge clk);
        bus.tick = 1; bus.run = 1;
        #2 rst_n = 1'b0;
        #1 check("async_reset", longint'(dut_snap()), 0);
        model_reset();
        repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("post_reset_idle", bus.active, 0);
        check("post_reset_gap", bus.gap_height, 0);

        // Randomised traffic against the model.
        for (int k = 0; k < 6000; k++) begin
            if ($urandom_range(0, 99) == 0) bus.level = 2'($urandom_range(0, 3));
            cyc($urandom_range(0, 1) == 1,
                $urandom_range(0, 19) != 0,
                $urandom_range(0, 299) == 0,
                $urandom_range(0, 999) == 0);
        end
        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
